instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000: address of the first fetch after reset.
REQ-002 Parameter NOP, default 32'h0000_0013 (addi x0,x0,0): value driven on instr when no valid instruction is available.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 imem_req  output  1  fetch request valid.
REQ-006 imem_addr  output  32  word-aligned fetch address; bits [1:0] always 0.
REQ-007 imem_gnt  input  1  memory accepts the request in the cycle imem_req&imem_gnt.
REQ-008 imem_rvalid  input  1  response valid; exactly one response per accepted request, earliest the cycle after acceptance, in order.
REQ-009 imem_rdata  input  32  instruction word, valid with imem_rvalid.
REQ-010 redirect  input  1  one-cycle pulse: flush and restart fetch at redirect_pc.
REQ-011 redirect_pc  input  32  new fetch address; bits [1:0] ignored, forced to 0.
REQ-012 stall  input  1  downstream not consuming; head instruction held.
REQ-013 instr  output  32  instruction word presented to the decoder.
REQ-014 instr_pc  output  32  address of instr.
REQ-015 instr_valid  output  1  instr/instr_pc hold a real instruction.

Function
REQ-016 Reset values: imem_req=0, imem_addr=RESET_PC, instr=NOP, instr_pc=0, instr_valid=0; pc register=RESET_PC; buffer empty; state IDLE.
REQ-017 State machine IDLE/REQ/WAIT: IDLE->REQ on first cycle after reset release; REQ holds imem_req=1 until gnt, then ->WAIT; WAIT->REQ on imem_rvalid if buffer has a free slot after that cycle's pop, else ->IDLE; IDLE->REQ when a slot frees.
REQ-018 At most one request outstanding; imem_req only asserted in REQ; imem_addr stable while imem_req=1 and not granted.
REQ-019 pc advances by 4 (mod 2^32, wrap from 32'hFFFF_FFFC to 0) on each accepted request.
REQ-020 Two-entry FIFO buffers {word, pc}; push on imem_rvalid of a non-discarded response; pop when instr_valid=1 and stall=0.
REQ-021 Head of FIFO drives instr/instr_pc combinationally; instr_valid=!empty; when empty instr=NOP, instr_pc unchanged from last head.
REQ-022 Throughput: with gnt tied high, rvalid one cycle after gnt and stall=0, one instruction per two cycles.
REQ-023 Simultaneous push and pop with FIFO full is legal: count unchanged.
REQ-024 Push into full FIFO cannot occur (REQ-017 guarantees); assertion in bench.
REQ-025 redirect: FIFO flushed same edge, pc=redirect_pc&~3; if request outstanding (WAIT), its response is discarded via drop flag and state stays WAIT then ->REQ; if in REQ not granted, imem_addr switches to redirect_pc next cycle; if in REQ and gnt same cycle, that request becomes discarded.
REQ-026 redirect same cycle as rvalid: response discarded; redirect same cycle as pop: flush wins.
REQ-027 redirect has priority over stall; stall does not block redirect.
REQ-028 instr and instr_pc hold stable while stall=1 and instr_valid=1.

Reset
REQ-029 rst_n low at any time, including mid-request, forces REQ-016 values immediately; responses for pre-reset requests arriving after release are discarded (drop flag set by reset if a request was outstanding is not required; memory is reset together).
REQ-030 First imem_req=1 with imem_addr=RESET_PC in the second rising edge after rst_n deasserts.

Verification
REQ-031 Reset release, gnt=1, rvalid 1 cycle later, rdata 32'h0050_0093 -> instr_valid=1, instr=32'h0050_0093, instr_pc=32'h8000_0000; next fetch addr 32'h8000_0004.
REQ-032 stall=1 for 10 cycles after two fetches -> FIFO full, imem_req=0, instr held at pc 32'h8000_0000; stall release -> pc ...0000, ...0004 consumed in order, fetch resumes at ...0008.
REQ-033 redirect to 32'h8000_0103 while in WAIT -> pending response dropped, next imem_addr=32'h8000_0100, instr_valid=0 until its response.
REQ-034 redirect same cycle as rvalid -> that word never appears on instr.
REQ-035 gnt held low 5 cycles -> imem_addr stable, imem_req stays 1; instr=NOP, instr_valid=0.
REQ-036 redirect to 32'hFFFF_FFFC, two fetches -> addresses FFFF_FFFC then 0000_0000.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch unit: single-outstanding request front end feeding a
// two-entry {word, pc} buffer whose head is presented to the decoder.
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter logic [31:0] NOP      = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        stall,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        instr_valid
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   state_t      state_r;
   logic        req_r;
   logic [31:0] pc_r;
   logic [31:0] out_pc_r;
   logic        drop_r;

   logic [31:0] fifo_word_r [2];
   logic [31:0] fifo_pc_r   [2];
   logic        rd_ptr_r;
   logic        wr_ptr_r;
   logic [1:0]  count_r;
   logic [31:0] last_pc_r;

   logic [31:0] redirect_addr_s;
   logic [31:0] pc_next_s;
   logic [31:0] head_word_s;
   logic [31:0] head_pc_s;
   logic [1:0]  count_next_s;
   logic        valid_s;
   logic        accept_s;
   logic        resp_s;
   logic        push_s;
   logic        pop_s;
   logic        room_s;

   // Handshake decode, buffer occupancy forecast and next fetch address
   always_comb begin
      redirect_addr_s = redirect_pc & 32'hFFFF_FFFC;
      valid_s         = (count_r != 2'd0);
      accept_s        = (state_r == ST_REQ) && imem_gnt;
      resp_s          = (state_r == ST_WAIT) && imem_rvalid;
      push_s          = resp_s && !drop_r && !redirect;
      pop_s           = valid_s && !stall;
      if (push_s && !pop_s) begin
         count_next_s = count_r + 2'd1;
      end else if (pop_s && !push_s) begin
         count_next_s = count_r - 2'd1;
      end else begin
         count_next_s = count_r;
      end
      // A redirect empties the buffer, so there is always room afterwards
      if (redirect) begin
         room_s = 1'b1;
      end else begin
         room_s = (count_next_s != 2'd2);
      end
      if (redirect) begin
         pc_next_s = redirect_addr_s;
      end else if (accept_s) begin
         pc_next_s = pc_r + 32'd4;
      end else begin
         pc_next_s = pc_r;
      end
   end

   // Fetch state machine with registered request, address and drop flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= ST_IDLE;
         req_r    <= 1'b0;
         pc_r     <= RESET_PC & 32'hFFFF_FFFC;
         out_pc_r <= 32'h0000_0000;
         drop_r   <= 1'b0;
      end else begin
         pc_r <= pc_next_s;
         case (state_r)
            ST_IDLE: begin
               drop_r <= 1'b0;
               if (room_s) begin
                  state_r <= ST_REQ;
                  req_r   <= 1'b1;
               end else begin
                  state_r <= ST_IDLE;
                  req_r   <= 1'b0;
               end
            end
            ST_REQ: begin
               if (accept_s) begin
                  state_r  <= ST_WAIT;
                  req_r    <= 1'b0;
                  drop_r   <= redirect;
                  out_pc_r <= pc_r;
               end else begin
                  state_r <= ST_REQ;
                  req_r   <= 1'b1;
                  drop_r  <= 1'b0;
               end
            end
            ST_WAIT: begin
               if (resp_s) begin
                  drop_r <= 1'b0;
                  if (room_s) begin
                     state_r <= ST_REQ;
                     req_r   <= 1'b1;
                  end else begin
                     state_r <= ST_IDLE;
                     req_r   <= 1'b0;
                  end
               end else begin
                  state_r <= ST_WAIT;
                  req_r   <= 1'b0;
                  drop_r  <= drop_r | redirect;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               req_r   <= 1'b0;
               drop_r  <= 1'b0;
            end
         endcase
      end
   end

   // Two-entry instruction buffer; flush on redirect overrides push and pop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            fifo_word_r[i] <= 32'h0000_0000;
            fifo_pc_r[i]   <= 32'h0000_0000;
         end
         rd_ptr_r  <= 1'b0;
         wr_ptr_r  <= 1'b0;
         count_r   <= 2'd0;
         last_pc_r <= 32'h0000_0000;
      end else begin
         if (valid_s) begin
            last_pc_r <= head_pc_s;
         end else begin
            last_pc_r <= last_pc_r;
         end
         if (redirect) begin
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
         end else begin
            if (push_s) begin
               fifo_word_r[wr_ptr_r] <= imem_rdata;
               fifo_pc_r[wr_ptr_r]   <= out_pc_r;
               wr_ptr_r              <= ~wr_ptr_r;
            end
            if (pop_s) begin
               rd_ptr_r <= ~rd_ptr_r;
            end
            count_r <= count_next_s;
         end
      end
   end

   // Head of buffer drives the decoder; NOP and last pc when empty
   always_comb begin
      head_word_s = fifo_word_r[rd_ptr_r];
      head_pc_s   = fifo_pc_r[rd_ptr_r];
      instr_valid = valid_s;
      if (valid_s) begin
         instr    = head_word_s;
         instr_pc = head_pc_s;
      end else begin
         instr    = NOP;
         instr_pc = last_pc_r;
      end
   end

   assign imem_req  = req_r;
   assign imem_addr = pc_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a per-cycle vector table for the basic
// fetch/stall flow plus hand-written redirect, wrap and reset sequences.
module tb_instr_fetch;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        stall = 1'b0;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;

   int checks = 0;
   int errors = 0;

   instr_fetch dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .stall       (stall),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_valid (instr_valid)
   );

   always #5 clk = ~clk;

   // A response must never land in a full buffer
   always @(posedge clk) begin
      if (rst_n === 1'b1 && dut.push_s && dut.count_r == 2'd2) begin
         errors++;
         $display("FAIL fifo_overflow: push with count %0d, required count below 2", dut.count_r);
      end
   end

   typedef struct {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
      logic        stall;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_instr;
      logic [31:0] e_pc;
   } vec_t;

   vec_t vecs [16];

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic e_req, input logic [31:0] e_addr,
                          input logic e_valid, input logic [31:0] e_instr, input logic [31:0] e_pc);
      chk1 ({tag, ".imem_req"},    imem_req,    e_req);
      chk32({tag, ".imem_addr"},   imem_addr,   e_addr);
      chk1 ({tag, ".instr_valid"}, instr_valid, e_valid);
      chk32({tag, ".instr"},       instr,       e_instr);
      chk32({tag, ".instr_pc"},    instr_pc,    e_pc);
   endtask

   // Apply one cycle of inputs at the falling edge, return at the next falling edge
   task automatic step(input logic g, input logic rv, input logic [31:0] rd,
                       input logic rdr, input logic [31:0] rpc, input logic st);
      imem_gnt    = g;
      imem_rvalid = rv;
      imem_rdata  = rd;
      redirect    = rdr;
      redirect_pc = rpc;
      stall       = st;
      @(posedge clk);
      @(negedge clk);
      imem_rvalid = 1'b0;
      redirect    = 1'b0;
   endtask

   // Asynchronous reset from whatever state the DUT is in, then release on a falling edge
   task automatic do_reset(input string tag);
      @(negedge clk);
      imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect = 1'b0; stall = 1'b0;
      rst_n = 1'b0;
      #1;
      chk_out({tag, ".reset"}, 1'b0, 32'h8000_0000, 1'b0, NOP, 32'h0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      // gnt, rvalid, rdata, stall | req, addr, valid, instr, instr_pc
      vecs[0]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h8000_0000, 1'b0, NOP,           32'h0};
      vecs[1]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h8000_0000, 1'b0, NOP,           32'h0};
      vecs[2]  = '{1'b1, 1'b1, 32'h0050_0093, 1'b0, 1'b0, 32'h8000_0004, 1'b0, NOP,           32'h0};
      vecs[3]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h8000_0004, 1'b1, 32'h0050_0093, 32'h8000_0000};
      vecs[4]  = '{1'b1, 1'b1, 32'h0010_0113, 1'b0, 1'b0, 32'h8000_0008, 1'b0, NOP,           32'h8000_0000};
      vecs[5]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h8000_0008, 1'b1, 32'h0010_0113, 32'h8000_0004};
      vecs[6]  = '{1'b1, 1'b1, 32'h0020_0193, 1'b1, 1'b0, 32'h8000_000C, 1'b0, NOP,           32'h8000_0004};
      vecs[7]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h8000_000C, 1'b1, 32'h0020_0193, 32'h8000_0008};
      vecs[8]  = '{1'b1, 1'b1, 32'h0030_0213, 1'b1, 1'b0, 32'h8000_0010, 1'b1, 32'h0020_0193, 32'h8000_0008};
      vecs[9]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h8000_0010, 1'b1, 32'h0020_0193, 32'h8000_0008};
      vecs[10] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h8000_0010, 1'b1, 32'h0020_0193, 32'h8000_0008};
      vecs[11] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h8000_0010, 1'b1, 32'h0030_0213, 32'h8000_000C};
      vecs[12] = '{1'b1, 1'b1, 32'h0040_0293, 1'b0, 1'b0, 32'h8000_0014, 1'b0, NOP,           32'h8000_000C};
      vecs[13] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h8000_0014, 1'b1, 32'h0040_0293, 32'h8000_0010};
      vecs[14] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h8000_0014, 1'b0, NOP,           32'h8000_0010};
      vecs[15] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h8000_0014, 1'b0, NOP,           32'h8000_0010};

      // Table: first fetch, throughput, buffer fill under stall, drain, gnt low
      do_reset("tbl");
      for (int i = 0; i < 16; i++) begin
         chk_out($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr,
                 vecs[i].e_valid, vecs[i].e_instr, vecs[i].e_pc);
         step(vecs[i].gnt, vecs[i].rvalid, vecs[i].rdata, 1'b0, 32'h0, vecs[i].stall);
      end

      // Two fetches under a long stall, then drain in order
      do_reset("s1");
      step(1'b1, 1'b0, 32'h0,         1'b0, 32'h0, 1'b1);
      step(1'b1, 1'b0, 32'h0,         1'b0, 32'h0, 1'b1);
      step(1'b1, 1'b1, 32'h1111_0013, 1'b0, 32'h0, 1'b1);
      step(1'b1, 1'b0, 32'h0,         1'b0, 32'h0, 1'b1);
      step(1'b1, 1'b1, 32'h2222_0013, 1'b0, 32'h0, 1'b1);
      chk_out("s1.full", 1'b0, 32'h8000_0008, 1'b1, 32'h1111_0013, 32'h8000_0000);
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
         chk1 ($sformatf("s1.hold%0d.imem_req", i), imem_req, 1'b0);
         chk32($sformatf("s1.hold%0d.instr", i),    instr,    32'h1111_0013);
         chk32($sformatf("s1.hold%0d.instr_pc", i), instr_pc, 32'h8000_0000);
      end
      step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      chk_out("s1.pop1", 1'b1, 32'h8000_0008, 1'b1, 32'h2222_0013, 32'h8000_0004);
      step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      chk_out("s1.pop2", 1'b1, 32'h8000_0008, 1'b0, NOP, 32'h8000_0004);

      // Redirect while waiting: pending response dropped, refetch aligned target
      do_reset("s2");
      step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_0103, 1'b0);
      chk_out("s2.redir", 1'b0, 32'h8000_0100, 1'b0, NOP, 32'h0);
      step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);
      chk_out("s2.drop", 1'b1, 32'h8000_0100, 1'b0, NOP, 32'h0);
      step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      chk_out("s2.wait", 1'b0, 32'h8000_0104, 1'b0, NOP, 32'h0);
      step(1'b0, 1'b1, 32'h1234_0013, 1'b0, 32'h0, 1'b0);
      chk_out("s2.new", 1'b1, 32'h8000_0104, 1'b1, 32'h1234_0013, 32'h8000_0100);

      // Redirect with rvalid, with pop, and with gnt
      do_reset("s3");
      step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b1, 32'hBADD_0013, 1'b1, 32'h8000_0200, 1'b0);
      chk_out("s3.rv_redir", 1'b1, 32'h8000_0200, 1'b0, NOP, 32'h0);
      step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b1, 32'h600D_0013, 1'b0, 32'h0, 1'b0);
      chk_out("s3.good", 1'b1, 32'h8000_0204, 1'b1, 32'h600D_0013, 32'h8000_0200);
      step(1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_0300, 1'b0);
      chk_out("s3.pop_redir", 1'b1, 32'h8000_0300, 1'b0, NOP, 32'h8000_0200);
      step(1'b1, 1'b0, 32'h0, 1'b1, 32'h8000_0400, 1'b0);
      chk_out("s3.gnt_redir", 1'b0, 32'h8000_0400, 1'b0, NOP, 32'h8000_0200);
      step(1'b0, 1'b1, 32'hBAD2_0013, 1'b0, 32'h0, 1'b0);
      chk_out("s3.gnt_drop", 1'b1, 32'h8000_0400, 1'b0, NOP, 32'h8000_0200);

      // gnt held low, then redirect to the top word and wrap to zero
      do_reset("s4");
      step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         chk_out($sformatf("s4.nognt%0d", i), 1'b1, 32'h8000_0000, 1'b0, NOP, 32'h0);
         step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      end
      step(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0);
      chk_out("s4.top", 1'b1, 32'hFFFF_FFFC, 1'b0, NOP, 32'h0);
      step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      chk_out("s4.wrap", 1'b0, 32'h0000_0000, 1'b0, NOP, 32'h0);
      step(1'b0, 1'b1, 32'hAAAA_0013, 1'b0, 32'h0, 1'b0);
      chk_out("s4.first", 1'b1, 32'h0000_0000, 1'b1, 32'hAAAA_0013, 32'hFFFF_FFFC);
      step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      chk_out("s4.second_req", 1'b0, 32'h0000_0004, 1'b0, NOP, 32'hFFFF_FFFC);
      step(1'b0, 1'b1, 32'hBBBB_0013, 1'b0, 32'h0, 1'b0);
      chk_out("s4.second", 1'b1, 32'h0000_0004, 1'b1, 32'hBBBB_0013, 32'h0000_0000);

      // Reset asserted mid-request must restore reset values immediately
      do_reset("s5");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
